// File: rtl/arith_result_fifo.sv
// Result FIFO for the arithmetic unit. It picks the add, sub, mul or div result by opcode,
// tags divide-by-zero, and buffers {op, dz, result}.
// Latency: a push at edge N is visible at the head in cycle N+1. The head is first-word-fall-through
// from storage, with no input bypass.
// Backpressure: o_ready = !full, and a full FIFO refuses a push even when it pops in the same cycle.
// o_valid = !empty, and i_ready is ignored while the FIFO is empty.
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   i_valid / o_ready               upstream handshake
//   i_op, i_value_{add,sub,mul,div} opcode and the four candidate results
//   i_value_b                       divisor, used only to detect divide-by-zero
//   o_valid / i_ready               downstream handshake
//   o_op, o_result, o_div_zero      head entry (reads 0 while empty)
//   o_count                         number of entries held (0..DEPTH)
//   o_dz_errors                     saturating count of accepted divide-by-zero entries
module arith_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_value_add,
  input  logic [WIDTH-1:0] i_value_sub,
  input  logic [WIDTH-1:0] i_value_mul,
  input  logic [WIDTH-1:0] i_value_div,
  input  logic [WIDTH-1:0] i_value_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [1:0]       o_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_zero,
  output logic [AW:0]      o_count,
  output logic [7:0]       o_dz_errors
);

  typedef struct packed {
    logic [1:0]       op;
    logic             dz;
    logic [WIDTH-1:0] result;
  } entry_t;

  localparam logic [1:0]  OP_ADD   = 2'd0;
  localparam logic [1:0]  OP_SUB   = 2'd1;
  localparam logic [1:0]  OP_MUL   = 2'd2;
  localparam logic [1:0]  OP_DIV   = 2'd3;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        new_entry;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    dz_cnt;
  logic          push;
  logic          pop;

  assign o_ready = (count != FULL_CNT);
  assign o_valid = (count != '0);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  // Build the entry to store. A divide by zero stores all-ones, because the divider's quotient
  // is meaningless in that case.
  always_comb begin
    new_entry.op     = i_op;
    new_entry.dz     = (i_op == OP_DIV) && (i_value_b == '0);
    new_entry.result = '0;
    case (i_op)
      OP_ADD:  new_entry.result = i_value_add;
      OP_SUB:  new_entry.result = i_value_sub;
      OP_MUL:  new_entry.result = i_value_mul;
      OP_DIV:  new_entry.result = i_value_div;
      default: new_entry.result = '0;
    endcase
    if (new_entry.dz) begin
      new_entry.result = '1;
    end
  end

  // Storage is not reset. The head outputs are gated by o_valid, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dz_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && new_entry.dz && (dz_cnt != 8'hFF)) begin
        dz_cnt <= dz_cnt + 1'b1;
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign o_op        = o_valid ? head.op     : '0;
  assign o_result    = o_valid ? head.result : '0;
  assign o_div_zero  = o_valid ? head.dz     : 1'b0;
  assign o_count     = count;
  assign o_dz_errors = dz_cnt;

endmodule
